// File: rtl/playfield_tile_shifter_if.sv
// Tile-slice handshake between the playfield fetcher (master) and the
// tile shifter's prefetch buffer (slave).
interface playfield_tile_shifter_if;
  logic        gfx_valid;
  logic        gfx_ready;
  logic [31:0] gfx_planes;
  logic [3:0]  gfx_pal;
  logic        gfx_flip;

  modport master (
    output gfx_valid,
    output gfx_planes,
    output gfx_pal,
    output gfx_flip,
    input  gfx_ready
  );

  modport slave (
    input  gfx_valid,
    input  gfx_planes,
    input  gfx_pal,
    input  gfx_flip,
    output gfx_ready
  );
endinterface

// File: rtl/playfield_tile_shifter.sv
// Serialises 8-pixel, 4-bitplane tile slices from a 2-entry prefetch buffer
// into the per-pixel PFSR stream, one pixel per pix_en.
module playfield_tile_shifter (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pix_en,
  input  logic                            hstart,
  playfield_tile_shifter_if.slave         gfx,
  output logic [7:0]                      PFSR,
  output logic                            tile_strobe,
  output logic                            underflow
);

  typedef struct packed {
    logic        flip;
    logic [3:0]  pal;
    logic [31:0] planes;
  } slice_t;

  slice_t [1:0]    buf_q, buf_d;
  logic [1:0]      count_q, count_d;
  logic [2:0]      phase_q, phase_d;
  logic [3:0][7:0] plane_q, plane_d;
  logic [3:0]      pal_q, pal_d;
  logic            tile_strobe_q, tile_strobe_d;
  logic            underflow_q, underflow_d;

  logic            push;
  logic            boundary;
  logic            pop;
  slice_t          head;
  slice_t          incoming;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      r[b] = v[7 - b];
    end
    return r;
  endfunction

  assign gfx.gfx_ready = (count_q < 2'd2);
  assign push          = gfx.gfx_valid & gfx.gfx_ready;
  assign boundary      = pix_en & ((phase_q == 3'd7) | hstart);
  assign pop           = boundary & (count_q != 2'd0);
  assign head          = buf_q[0];
  assign incoming      = '{flip: gfx.gfx_flip, pal: gfx.gfx_pal, planes: gfx.gfx_planes};

  always_comb begin
    buf_d         = buf_q;
    count_d       = count_q;
    phase_d       = phase_q;
    plane_d       = plane_q;
    pal_d         = pal_q;
    tile_strobe_d = 1'b0;
    underflow_d   = underflow_q;

    if (boundary) begin
      phase_d       = '0;
      tile_strobe_d = 1'b1;
      if (pop) begin
        for (int unsigned i = 0; i < 4; i++) begin
          plane_d[i] = head.flip ? rev8(head.planes[i*8 +: 8]) : head.planes[i*8 +: 8];
        end
        pal_d = head.pal;
      end else begin
        plane_d     = '0;
        pal_d       = '0;
        underflow_d = 1'b1;
      end
    end else if (pix_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        plane_d[i] = {plane_q[i][6:0], 1'b0};
      end
      phase_d = phase_q + 3'd1;
    end

    // Pop shifts the buffer first so a same-cycle push lands behind the new head;
    // pop only uses the pre-push count, so an empty-buffer push is never bypassed.
    if (pop) begin
      buf_d[0] = buf_q[1];
      count_d  = count_q - 2'd1;
    end
    if (push) begin
      buf_d[count_d[0]] = incoming;
      count_d           = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q         <= '0;
      count_q       <= '0;
      phase_q       <= 3'd7;
      plane_q       <= '0;
      pal_q         <= '0;
      tile_strobe_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      count_q       <= count_d;
      phase_q       <= phase_d;
      plane_q       <= plane_d;
      pal_q         <= pal_d;
      tile_strobe_q <= tile_strobe_d;
      underflow_q   <= underflow_d;
    end
  end

  assign PFSR        = {pal_q, plane_q[3][7], plane_q[2][7], plane_q[1][7], plane_q[0][7]};
  assign tile_strobe = tile_strobe_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_playfield_tile_shifter.sv
// Directed, table-driven bench for playfield_tile_shifter with hand-computed
// expectations, plus hand-written back-pressure and mid-line reset sequences.
module tb_playfield_tile_shifter;

  logic       clk;
  logic       reset;
  logic       pix_en;
  logic       hstart;
  logic [7:0] PFSR;
  logic       tile_strobe;
  logic       underflow;

  int n_checks;
  int n_fail;

  playfield_tile_shifter_if gfx_if ();

  playfield_tile_shifter dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hstart      (hstart),
    .gfx         (gfx_if),
    .PFSR        (PFSR),
    .tile_strobe (tile_strobe),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pe;
    logic        hs;
    logic        v;
    logic [31:0] planes;
    logic [3:0]  pal;
    logic        flip;
    logic [7:0]  e_pfsr;
    logic        e_rdy;
    logic        e_strb;
    logic        e_unf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic pe, input logic hs, input logic v,
                              input logic [31:0] planes, input logic [3:0] pal,
                              input logic flip, input logic [7:0] e_pfsr,
                              input logic e_rdy, input logic e_strb, input logic e_unf);
    vec_t r;
    r.pe = pe; r.hs = hs; r.v = v; r.planes = planes; r.pal = pal; r.flip = flip;
    r.e_pfsr = e_pfsr; r.e_rdy = e_rdy; r.e_strb = e_strb; r.e_unf = e_unf;
    vt.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_pfsr, input logic e_rdy,
                         input logic e_strb, input logic e_unf);
    chk({tag, " PFSR"}, PFSR, e_pfsr);
    chk({tag, " ready"}, {7'd0, gfx_if.gfx_ready}, {7'd0, e_rdy});
    chk({tag, " strobe"}, {7'd0, tile_strobe}, {7'd0, e_strb});
    chk({tag, " underflow"}, {7'd0, underflow}, {7'd0, e_unf});
  endtask

  task automatic drive(input logic pe, input logic hs, input logic v,
                       input logic [31:0] planes, input logic [3:0] pal, input logic flip);
    pix_en             = pe;
    hstart             = hs;
    gfx_if.gfx_valid   = v;
    gfx_if.gfx_planes  = planes;
    gfx_if.gfx_pal     = pal;
    gfx_if.gfx_flip    = flip;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    //   pe hs v  planes         pal  flip  PFSR   rdy strb unf
    add(0, 0, 1, 32'h000000FF, 4'h3, 0,   8'h00, 1,  0,   0);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h31, 1,  1,   0);
    add(1, 0, 1, 32'h00000080, 4'h5, 1,   8'h31, 1,  0,   0);
    for (int i = 0; i < 6; i++)
      add(1, 0, 0, 32'h0,      4'h0, 0,   8'h31, 1,  0,   0);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h50, 1,  1,   0);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h50, 1,  0,   0);
    add(0, 0, 0, 32'h0,        4'h0, 0,   8'h50, 1,  0,   0);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 32'h0,      4'h0, 0,   8'h50, 1,  0,   0);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h51, 1,  0,   0);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h00, 1,  1,   1);
    add(0, 0, 1, 32'hAA000000, 4'hC, 0,   8'h00, 1,  0,   1);
    add(1, 1, 0, 32'h0,        4'h0, 0,   8'hC8, 1,  1,   1);
    add(1, 0, 1, 32'h0000FF00, 4'h9, 0,   8'hC0, 1,  0,   1);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'hC8, 1,  0,   1);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'hC0, 1,  0,   1);
    add(1, 1, 0, 32'h0,        4'h0, 0,   8'h92, 1,  1,   1);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h92, 1,  0,   1);
    add(0, 1, 0, 32'h0,        4'h0, 0,   8'h92, 1,  0,   1);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h92, 1,  0,   1);
    add(1, 1, 1, 32'h00F00000, 4'h6, 0,   8'h00, 1,  1,   1);
    add(1, 1, 0, 32'h0,        4'h0, 0,   8'h64, 1,  1,   1);
    add(1, 0, 0, 32'h0,        4'h0, 0,   8'h64, 1,  0,   1);

    step();
    step();
    reset = 1'b0;
    chk_all("reset", 8'h00, 1'b1, 1'b0, 1'b0);

    foreach (vt[k]) begin
      drive(vt[k].pe, vt[k].hs, vt[k].v, vt[k].planes, vt[k].pal, vt[k].flip);
      step();
      chk_all($sformatf("vec%0d", k), vt[k].e_pfsr, vt[k].e_rdy, vt[k].e_strb, vt[k].e_unf);
    end

    // Mid-line reset with a full buffer at phase 5
    drive(1'b0, 1'b0, 1'b1, 32'h000000FF, 4'h1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h0000FF00, 4'h2, 1'b0);
    step();
    chk("rst_seq full ready", {7'd0, gfx_if.gfx_ready}, 8'h00);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst_async", 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    chk_all("rst_first_pe", 8'h00, 1'b1, 1'b1, 1'b1);

    // Three slices offered back-to-back with gfx_valid held high
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h000000FF, 4'h1, 1'b0);
    step();
    chk_all("bb A", 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000FF00, 4'h2, 1'b0);
    step();
    chk_all("bb B", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'hFF000000, 4'h4, 1'b0);
    step();
    chk_all("bb pop A", 8'h11, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hFF000000, 4'h4, 1'b0);
    step();
    chk_all("bb C", 8'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("bb A pix%0d", i), PFSR, 8'h11);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bb B pix%0d", i), PFSR, 8'h22);
      if (i == 0) chk_all("bb pop B", 8'h22, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bb C pix%0d", i), PFSR, 8'h48);
    end
    step();
    chk_all("bb drained", 8'h00, 1'b1, 1'b1, 1'b1);

    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/playfield_tile_shifter.md
# playfield_tile_shifter

Serialises 4-bitplane playfield tile graphics into the per-pixel PFSR[7:0] stream consumed by the playfield horizontal scroll stage, which then applies fine scroll and produces PFX. The tile fetch logic pushes one 8-pixel tile slice at a time through a valid/ready handshake into a 2-entry prefetch buffer. Every 8 pixel enables the shifter pops a slice, applies optional horizontal flip, and shifts out one pixel per pixel enable.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel enable, one clk-wide pulse per pixel (the MCKR rate).
- hstart  in  1  line-start pulse. Sampled only when pix_en=1.
- gfx_valid  in  1  fetcher presents a tile slice.
- gfx_ready  out  1  buffer can accept a slice. Equals (count<2).
- gfx_planes  in  32  {plane3,plane2,plane1,plane0}, each 8 bits. Bit 7 is the leftmost pixel.
- gfx_pal  in  4  palette select for the slice.
- gfx_flip  in  1  horizontal flip for the slice.
- PFSR  out  8  {pal[3:0], p3,p2,p1,p0} current pixel.
- tile_strobe  out  1  one-clk pulse, registered, marks a slice-boundary load attempt.
- underflow  out  1  sticky flag. Cleared only by reset.

## Operation
State:
- buffer: 2 entries of {flip, pal, planes}, 37 bits each.
- count: 0..2.
- phase: 3 bits.
- four 8-bit plane shift registers.
- pal_q: 4 bits.

Behaviour:
- Push: gfx_valid & gfx_ready writes the slice at the tail and increments count.
- Boundary: a pix_en cycle with (phase==7) | hstart.
- On a boundary:
  - If count>0 (evaluated before this cycle's push): pop the head into the shift registers. When the entry's flip=1, bit-reverse each plane. pal_q takes the entry's pal.
  - If count==0: load all four planes and pal_q with 0, and set underflow.
  - In both cases phase<=0 and tile_strobe<=1.
- Non-boundary pix_en: shift each plane register left by 1, filling with 0. phase<=phase+1.
- No pix_en: shift registers, phase and pal_q hold. Pushes are still accepted.
- PFSR = {pal_q, plane3[7], plane2[7], plane1[7], plane0[7]}, taken directly from registers.
- Simultaneous push and pop: count is unchanged, FIFO order is preserved, and the head advances.
- Push into an empty buffer on the same cycle as a boundary: no bypass. The boundary underflows and the pushed slice is kept for the next boundary.
- hstart forces a boundary regardless of phase. It realigns phase mid-tile, and the remaining pixels of the current slice are discarded. The buffer is not flushed.
- hstart with pix_en=0 is ignored.

## Timing
Reset values:
- PFSR=0x00, tile_strobe=0, underflow=0, count=0, gfx_ready=1.
- phase=7, so the first pix_en is a boundary.
- All plane and pal registers are 0.

Latency and cadence:
- A pop on the boundary pix_en cycle appears on PFSR one clk later as pixel 0 of the slice. Each following pix_en advances one pixel.
- A new slice is loaded every 8 pix_en, so a slice's pixel 7 is followed directly by the next slice's pixel 0.
- gfx_ready is registered-state only (count<2) and has no combinational path from pix_en. A pop frees a slot one clk later.
- underflow asserts one clk after the failing boundary and remains set.
- Asserting reset mid-line returns all state to the reset values immediately and discards both buffer entries. Deasserting it resumes with phase=7.

## Test plan
- Reset, push slice A (planes 0xFF/0x00/0x00/0x00, pal 0x3, flip 0), then 8 pix_en pulses -> PFSR reads 0x31 for all 8 pixels; tile_strobe pulses once; underflow=0.
- Push slice planes0=0x80 with flip=1 and pal 0x5 -> PFSR is 0x50 for pixels 0..6 and 0x51 on pixel 7.
- Push 3 slices back-to-back with gfx_valid held high -> gfx_ready drops after 2; the third slice is accepted only on the clk after the first boundary pop; the output order is A,B,C.
- Leave the buffer empty and issue pix_en -> underflow=1 one clk later and PFSR=0x00; a later push followed by the next boundary outputs normal pixels, and underflow stays 1.
- Assert hstart together with pix_en at phase 3 mid-slice, with 1 entry buffered -> the buffered slice loads immediately, the old slice's remaining 4 pixels are never output, and tile_strobe pulses.
- Assert reset while count=2 and phase=5 -> count=0, gfx_ready=1, PFSR=0x00, and the first subsequent pix_en is a boundary.
